// File: rtl/rip_bram_rmw_ctrl.sv
// Requester-side controller for BRAM port 1: valid/ready word bus with byte strobes,
// partial writes turned into read-modify-write, reads returned through a registered response.
module rip_bram_rmw_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic                      req_we,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      bram_enable,
    output logic [ADDR_WIDTH-1:0]     bram_addr,
    output logic                      bram_we,
    output logic [DATA_WIDTH-1:0]     bram_din,
    input  logic [DATA_WIDTH-1:0]     bram_dout
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_WAIT   = 2'd1,
        RMW_MERGE = 2'd2,
        RSP       = 2'd3
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [NB-1:0]           lat_strb;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic                    latch_en;
    logic [DATA_WIDTH-1:0]   merged;
    logic                    bram_enable_raw;
    logic                    bram_we_raw;
    logic                    req_ready_raw;

    // Byte merge of latched write data over the old line returned by the BRAM
    always_comb begin
        merged = bram_dout;
        for (int i = 0; i < int'(NB); i++) begin
            if (lat_strb[i]) merged[8*i +: 8] = lat_wdata[8*i +: 8];
        end
    end

    // Next-state and BRAM port drive
    always_comb begin
        state_next      = state;
        req_ready_raw   = 1'b0;
        bram_enable_raw = 1'b0;
        bram_we_raw     = 1'b0;
        bram_addr       = req_addr;
        bram_din        = req_wdata;
        latch_en        = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready_raw = 1'b1;
                if (req_valid) begin
                    if (!req_we) begin
                        bram_enable_raw = 1'b1;
                        state_next      = RD_WAIT;
                    end else if (&req_wstrb) begin
                        bram_enable_raw = 1'b1;
                        bram_we_raw     = 1'b1;
                    end else if (|req_wstrb) begin
                        bram_enable_raw = 1'b1;
                        latch_en        = 1'b1;
                        state_next      = RMW_MERGE;
                    end
                end
            end
            RD_WAIT: state_next = RSP;
            RMW_MERGE: begin
                bram_enable_raw = 1'b1;
                bram_we_raw     = 1'b1;
                bram_addr       = lat_addr;
                bram_din        = merged;
                state_next      = IDLE;
            end
            RSP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset must silence the port immediately, not just at the next edge
    assign req_ready   = req_ready_raw & rstn;
    assign bram_enable = bram_enable_raw & rstn;
    assign bram_we     = bram_we_raw & rstn;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            lat_addr  <= '0;
            lat_strb  <= '0;
            lat_wdata <= '0;
        end else begin
            state     <= state_next;
            rsp_valid <= (state_next == RSP);
            if (state == RD_WAIT) rsp_rdata <= bram_dout;
            if (latch_en) begin
                lat_addr  <= req_addr;
                lat_strb  <= req_wstrb;
                lat_wdata <= req_wdata;
            end
        end
    end

endmodule

// File: doc/rip_bram_rmw_ctrl.md
Name: rip_bram_rmw_ctrl

Overview:
- Requester-side controller for port 1 of the team's 2-read/1-write block RAM.
- The BRAM port accepts line-wise writes only, and read data arrives one cycle after the address.
- This block presents a valid/ready word-addressed bus with byte strobes. It converts partial-strobe writes into a read-modify-write sequence and returns read data through a registered response handshake.
- Sits between the core's load/store unit and the BRAM's port 1 (enable/addr/we/din/dout).

Parameters:
- DATA_WIDTH, 32, word width in bits. Must be a multiple of 8.
- ADDR_WIDTH, 10, word address width. The BRAM depth is 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock, all logic on the rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_addr  in  ADDR_WIDTH  word address
- req_we  in  1  1 = write, 0 = read
- req_wstrb  in  DATA_WIDTH/8  byte write strobes; bit i covers bits [8i+7:8i]
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  DATA_WIDTH  read data
- bram_enable  out  1  to BRAM enable_1
- bram_addr  out  ADDR_WIDTH  to BRAM addr_1
- bram_we  out  1  to BRAM we_1
- bram_din  out  DATA_WIDTH  to BRAM din_1
- bram_dout  in  DATA_WIDTH  from BRAM dout_1, valid one cycle after an enabled access

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE; rsp_valid = 0; rsp_rdata = 0; latched request registers = 0.
  - bram_enable, bram_we and req_ready are forced to 0 while rstn is low.
- Only one transaction is outstanding at a time.
- FSM states: IDLE, RD_WAIT, RMW_MERGE, RSP.
- req_ready = 1 only in IDLE (rstn high). It is combinational from state.
- Accepting a request in IDLE at cycle T:
  - Read (req_we=0): in cycle T, bram_enable=1, bram_we=0, bram_addr=req_addr. Go to RD_WAIT.
    - At T+1, capture bram_dout into rsp_rdata. Go to RSP.
    - rsp_valid rises at T+2.
  - Full write (req_we=1, all strobes set): in cycle T, bram_enable=1, bram_we=1, bram_din=req_wdata. Stay in IDLE. No response is generated. Back-to-back full writes are accepted every cycle.
  - Partial write (some strobes set, not all): in cycle T, issue a BRAM read of req_addr. Latch addr, wstrb and wdata. Go to RMW_MERGE.
    - At T+1, drive bram_enable=1, bram_we=1, bram_addr=latched addr. For each byte i, bram_din byte i = latched wdata byte i if wstrb[i], else bram_dout byte i.
    - Return to IDLE. req_ready is high again at T+2. No response is generated.
  - Zero-strobe write: accepted in one cycle, no BRAM access (bram_enable=0), stays in IDLE. Treated as a no-op.
- RSP state:
  - rsp_valid=1. rsp_rdata is stable until the handshake.
  - When rsp_valid && rsp_ready: go to IDLE, and rsp_valid falls next cycle. No request is accepted in that same cycle, so the minimum read-to-read spacing is 3 cycles.
  - rsp_ready has no effect when rsp_valid=0.
- Ordering: a read issued after a write to the same address returns the written data. The write commits at the clock edge before the read's BRAM access.
- In RD_WAIT and RMW_MERGE, req_* inputs are ignored. Only latched copies are used.
- Reset mid-operation:
  - Reset asserted in RMW_MERGE before the clock edge: the merge write does not occur and BRAM contents are unchanged.
  - Reset in RD_WAIT or RSP: the pending response is discarded.
- Address wrap: addresses are taken modulo 2**ADDR_WIDTH, with no error signalling.
- When BRAM outputs are not in use, bram_addr and bram_din are don't-care with bram_enable=0.

Test Plan:
- Full write addr 0x005 data 0xDEADBEEF, strobe 4'hF; then read 0x005 → bram_we pulses for 1 cycle; rsp_valid rises 2 cycles after read accept; rsp_rdata = 0xDEADBEEF.
- Write 0x010 = 0x11223344, then partial write 0x010 data 0xAABBCCDD strobe 4'b0101, then read → rsp_rdata = 0x11BB33DD; req_ready low exactly 1 cycle during the RMW.
- Read with rsp_ready held low 5 cycles → rsp_valid stays 1, rsp_rdata stable, req_ready 0 throughout; rsp_ready=1 → rsp_valid drops the next cycle and req_ready returns.
- 4 back-to-back full writes to 0x3FC..0x3FF with req_valid held high → 4 consecutive cycles with bram_we=1; readback of each address matches.
- Zero-strobe write to 0x020 holding 0x55555555 → no bram_enable pulse; readback = 0x55555555.
- Assert rstn low in the RMW_MERGE cycle of a partial write to 0x030 (old value 0x12345678) → no bram_we; after release req_ready=1, rsp_valid=0; readback of 0x030 = 0x12345678.
